// File: rtl/vred_seq.sv
// vred_seq: reduction sequencer in front of the vector AND/OR/XOR reduction pipeline.
// Accepts one command, reads the vs2 register group one beat per cycle, fills tail elements of
// the last beat with the operation identity, and holds off new commands until red_done.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (ready only while idle)
//   cmd_opsel/sew/vl/vs2_addr/vs1/vd_addr  command fields
//   rf_rd_en/rf_rd_addr           register-file read request
//   rf_rd_data                    read data, valid one cycle after rf_rd_en
//   red_valid/start/end           beat qualifiers to the reduction pipeline
//   red_vec0/red_vec1             masked vs2 beat / captured scalar operand
//   red_opsel/red_sew/red_addr    captured command fields
//   red_done                      reduction pipeline completion
//   busy                          sequencer not idle
module vred_seq #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned VL_WIDTH   = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_opsel,
  input  logic [1:0]            cmd_sew,
  input  logic [VL_WIDTH-1:0]   cmd_vl,
  input  logic [ADDR_WIDTH-1:0] cmd_vs2_addr,
  input  logic [DATA_WIDTH-1:0] cmd_vs1,
  input  logic [ADDR_WIDTH-1:0] cmd_vd_addr,
  output logic                  rf_rd_en,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
  output logic                  red_valid,
  output logic                  red_start,
  output logic                  red_end,
  output logic [DATA_WIDTH-1:0] red_vec0,
  output logic [DATA_WIDTH-1:0] red_vec1,
  output logic [1:0]            red_opsel,
  output logic [1:0]            red_sew,
  output logic [ADDR_WIDTH-1:0] red_addr,
  input  logic                  red_done,
  output logic                  busy
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;

  typedef enum logic [1:0] {StIdle = 2'd0, StRead = 2'd1, StWait = 2'd2} state_e;

  state_e state_q, state_d;

  // Captured command
  logic [1:0]            opsel_q, sew_q;
  logic [VL_WIDTH-1:0]   nbeats_q, k_q;
  logic [3:0]            rem_q;
  logic [ADDR_WIDTH-1:0] vs2_q, vd_q;
  logic [DATA_WIDTH-1:0] vs1_q;

  // Delay line travelling alongside each read
  logic       beat_valid_q, beat_first_q, beat_last_q;
  logic [3:0] beat_rem_q;

  logic                  accept, rd_last;
  logic [3:0]            epb;
  logic [1:0]            epb_shift;
  logic [VL_WIDTH:0]     vl_round;
  logic [VL_WIDTH-1:0]   cmd_nbeats, cmd_rem_full;
  logic [DATA_WIDTH-1:0] keep, ident;

  // epb = 8 >> sew = 2^(3-sew), so dividing by epb is a right shift by 3-sew.
  assign epb          = 4'd8 >> cmd_sew;
  assign epb_shift    = 2'd3 - cmd_sew;
  assign vl_round     = {1'b0, cmd_vl} + (VL_WIDTH+1)'(epb - 4'd1);
  assign cmd_nbeats   = (cmd_vl == '0) ? VL_WIDTH'(1) : VL_WIDTH'(vl_round >> epb_shift);
  assign cmd_rem_full = cmd_vl - ((cmd_nbeats - VL_WIDTH'(1)) << epb_shift);

  // Illegal opsel completes the handshake but never leaves idle.
  assign accept  = cmd_valid && (state_q == StIdle) && (cmd_opsel != 2'b00);
  assign rd_last = (k_q == nbeats_q - VL_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept)   state_d = StRead;
      StRead:  if (rd_last)  state_d = StWait;
      StWait:  if (red_done) state_d = StIdle;
      default:               state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_ready  = (state_q == StIdle);
    busy       = (state_q != StIdle);
    rf_rd_en   = (state_q == StRead);
    rf_rd_addr = rf_rd_en ? (vs2_q + ADDR_WIDTH'(k_q)) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opsel_q      <= '0;
      sew_q        <= '0;
      nbeats_q     <= '0;
      rem_q        <= '0;
      vs2_q        <= '0;
      vs1_q        <= '0;
      vd_q         <= '0;
      k_q          <= '0;
      beat_valid_q <= 1'b0;
      beat_first_q <= 1'b0;
      beat_last_q  <= 1'b0;
      beat_rem_q   <= '0;
    end else begin
      if (accept) begin
        opsel_q  <= cmd_opsel;
        sew_q    <= cmd_sew;
        nbeats_q <= cmd_nbeats;
        rem_q    <= 4'(cmd_rem_full);
        vs2_q    <= cmd_vs2_addr;
        vs1_q    <= cmd_vs1;
        vd_q     <= cmd_vd_addr;
        k_q      <= '0;
      end else if (rf_rd_en) begin
        k_q <= k_q + VL_WIDTH'(1);
      end
      beat_valid_q <= rf_rd_en;
      beat_first_q <= rf_rd_en && (k_q == '0);
      beat_last_q  <= rf_rd_en && rd_last;
      beat_rem_q   <= rf_rd_en ? rem_q : 4'd0;
    end
  end

  // Byte b belongs to element b >> sew; elements at or past rem on the last beat become identity.
  always_comb begin
    keep = '1;
    for (int b = 0; b < NumBytes; b++) begin
      if (beat_last_q && ((4'(b) >> sew_q) >= beat_rem_q)) begin
        keep[8*b +: 8] = 8'h00;
      end
    end
    ident    = (opsel_q == 2'b01) ? '1 : '0;
    red_vec0 = beat_valid_q ? ((rf_rd_data & keep) | (ident & ~keep)) : '0;
  end

  assign red_valid = beat_valid_q;
  assign red_start = beat_first_q;
  assign red_end   = beat_last_q;
  assign red_vec1  = vs1_q;
  assign red_opsel = opsel_q;
  assign red_sew   = sew_q;
  assign red_addr  = vd_q;

endmodule

// File: tb/tb_vred_seq.sv
// Bench for vred_seq: directed steps plus random commands checked against a behavioural model
// of the beat stream and a simple register-file model.
module tb_vred_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_opsel, cmd_sew;
  logic [10:0] cmd_vl;
  logic [31:0] cmd_vs2_addr, cmd_vd_addr;
  logic [63:0] cmd_vs1;
  logic        rf_rd_en;
  logic [31:0] rf_rd_addr;
  logic [63:0] rf_rd_data;
  logic        red_valid, red_start, red_end;
  logic [63:0] red_vec0, red_vec1;
  logic [1:0]  red_opsel, red_sew;
  logic [31:0] red_addr;
  logic        red_done, busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] mem [logic [31:0]];
  logic        pend_en;
  logic [31:0] pend_addr;

  vred_seq dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_opsel    (cmd_opsel),
    .cmd_sew      (cmd_sew),
    .cmd_vl       (cmd_vl),
    .cmd_vs2_addr (cmd_vs2_addr),
    .cmd_vs1      (cmd_vs1),
    .cmd_vd_addr  (cmd_vd_addr),
    .rf_rd_en     (rf_rd_en),
    .rf_rd_addr   (rf_rd_addr),
    .rf_rd_data   (rf_rd_data),
    .red_valid    (red_valid),
    .red_start    (red_start),
    .red_end      (red_end),
    .red_vec0     (red_vec0),
    .red_vec1     (red_vec1),
    .red_opsel    (red_opsel),
    .red_sew      (red_sew),
    .red_addr     (red_addr),
    .red_done     (red_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_get(logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a ^ 32'hDEAD_BEEF, a * 32'h9E37_79B9};
  endfunction

  // Register file: the request seen mid-cycle is answered right after the next edge;
  // otherwise the data bus carries garbage.
  always @(negedge clk) begin
    pend_en   = rf_rd_en;
    pend_addr = rf_rd_addr;
  end
  always @(posedge clk) begin
    if (pend_en) rf_rd_data <= mem_get(pend_addr);
    else         rf_rd_data <= {$urandom, $urandom};
  end

  // Expected beat: vs2 word with, on the last beat, elements at or past rem set to identity.
  function automatic logic [63:0] model_beat(logic [31:0] a, int sew, logic [1:0] op, bit last,
                                             int rem);
    logic [63:0] v;
    int w;
    v = mem_get(a);
    w = 8 << sew;
    if (last) begin
      for (int i = 0; i < 64; i++) begin
        if (i / w >= rem) v[i] = (op == 2'b01);
      end
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string ctx);
    chk({ctx, " cmd_ready"}, cmd_ready, 1'b1);
    chk({ctx, " busy"}, busy, 1'b0);
    chk({ctx, " rf_rd_en"}, rf_rd_en, 1'b0);
    chk({ctx, " rf_rd_addr"}, rf_rd_addr, 32'h0);
    chk({ctx, " red_valid"}, red_valid, 1'b0);
    chk({ctx, " red_start"}, red_start, 1'b0);
    chk({ctx, " red_end"}, red_end, 1'b0);
    chk({ctx, " red_vec0"}, red_vec0, 64'h0);
    chk({ctx, " red_vec1"}, red_vec1, 64'h0);
    chk({ctx, " red_opsel"}, red_opsel, 2'b00);
    chk({ctx, " red_sew"}, red_sew, 2'b00);
    chk({ctx, " red_addr"}, red_addr, 32'h0);
  endtask

  // Starts at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic do_cmd(input logic [1:0] op, input logic [1:0] sew, input logic [10:0] vl,
                        input logic [31:0] vs2, input logic [63:0] vs1, input logic [31:0] vd,
                        input bit hold, input bit early_done, input int gap);
    int epb, nb, rem;
    logic [31:0] a;
    epb = 8 >> sew;
    nb  = (vl == 0) ? 1 : (int'(vl) + epb - 1) / epb;
    rem = int'(vl) - (nb - 1) * epb;
    cmd_valid    = 1'b1;
    cmd_opsel    = op;
    cmd_sew      = sew;
    cmd_vl       = vl;
    cmd_vs2_addr = vs2;
    cmd_vs1      = vs1;
    cmd_vd_addr  = vd;
    chk("cmd_ready at offer", cmd_ready, 1'b1);
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
    for (int j = 0; j <= nb; j++) begin
      red_done = early_done && (j == 0);
      a = vs2 + 32'(j);
      chk("rf_rd_en", rf_rd_en, (j < nb));
      if (j < nb) chk("rf_rd_addr", rf_rd_addr, a);
      chk("red_valid", red_valid, (j >= 1));
      chk("cmd_ready busy", cmd_ready, 1'b0);
      chk("busy", busy, 1'b1);
      if (j == 0) begin
        chk("red_vec0 idle", red_vec0, 64'h0);
      end else begin
        a = vs2 + 32'(j - 1);
        chk("red_vec0", red_vec0, model_beat(a, int'(sew), op, (j == nb), rem));
        chk("red_start", red_start, (j == 1));
        chk("red_end", red_end, (j == nb));
        chk("red_vec1", red_vec1, vs1);
        chk("red_opsel", red_opsel, op);
        chk("red_sew", red_sew, sew);
        chk("red_addr", red_addr, vd);
      end
      @(negedge clk);
    end
    red_done = 1'b0;
    for (int g = 0; g < gap; g++) begin
      chk("wait red_valid", red_valid, 1'b0);
      chk("wait red_vec0", red_vec0, 64'h0);
      chk("wait cmd_ready", cmd_ready, 1'b0);
      @(negedge clk);
    end
    red_done = 1'b1;
    chk("cmd_ready before done", cmd_ready, 1'b0);
    @(negedge clk);
    red_done = 1'b0;
    chk("cmd_ready after done", cmd_ready, 1'b1);
    chk("busy after done", busy, 1'b0);
    if (hold) cmd_valid = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    cmd_valid    = 1'b0;
    cmd_opsel    = 2'b00;
    cmd_sew      = 2'b00;
    cmd_vl       = '0;
    cmd_vs2_addr = '0;
    cmd_vs1      = '0;
    cmd_vd_addr  = '0;
    red_done     = 1'b0;
    rf_rd_data   = '0;

    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("cmd_ready after reset", cmd_ready, 1'b1);

    // OR, single full beat
    mem[32'h10] = 64'h0102_0408_1020_4080;
    do_cmd(2'b10, 2'd0, 11'd8, 32'h10, 64'h5555_0000_1234_5678, 32'h40, 1'b0, 1'b0, 1);

    // AND with tail fill
    mem[32'h20] = 64'h1111_1111_2222_2222;
    mem[32'h21] = 64'h3333_3333_4444_4444;
    do_cmd(2'b01, 2'd2, 11'd3, 32'h20, 64'hCAFE, 32'h41, 1'b0, 1'b0, 2);

    // XOR multi-beat, partial last beat
    do_cmd(2'b11, 2'd1, 11'd18, 32'h30, 64'h77, 32'h42, 1'b0, 1'b0, 0);

    // vl = 0: whole beat forced to identity
    do_cmd(2'b11, 2'd0, 11'd0, 32'h50, 64'hAB, 32'h43, 1'b0, 1'b0, 0);

    // cmd_valid held through READ/WAIT, early red_done ignored, then back-to-back command
    do_cmd(2'b10, 2'd3, 11'd4, 32'h60, 64'h1, 32'h44, 1'b1, 1'b1, 2);
    do_cmd(2'b01, 2'd0, 11'd13, 32'h70, 64'h2, 32'h45, 1'b0, 1'b0, 0);

    // Address wrap
    do_cmd(2'b11, 2'd3, 11'd3, 32'hFFFF_FFFF, 64'h3, 32'h46, 1'b0, 1'b0, 0);

    // Illegal opsel: accepted and dropped
    cmd_valid = 1'b1;
    cmd_opsel = 2'b00;
    cmd_vl    = 11'd8;
    chk("illegal cmd_ready", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("illegal rf_rd_en", rf_rd_en, 1'b0);
      chk("illegal red_valid", red_valid, 1'b0);
      chk("illegal busy", busy, 1'b0);
      @(negedge clk);
    end

    // Reset during the third read
    cmd_valid    = 1'b1;
    cmd_opsel    = 2'b10;
    cmd_sew      = 2'd0;
    cmd_vl       = 11'd64;
    cmd_vs2_addr = 32'h100;
    cmd_vs1      = 64'h99;
    cmd_vd_addr  = 32'h47;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rst-test read1 addr", rf_rd_addr, 32'h100);
    @(negedge clk);
    chk("rst-test beat1 start", red_start, 1'b1);
    @(negedge clk);
    chk("rst-test read3 en", rf_rd_en, 1'b1);
    chk("rst-test read3 addr", rf_rd_addr, 32'h102);
    rst = 1'b1;
    @(negedge clk);
    chk_quiet("mid-command reset");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post-reset red_end", red_end, 1'b0);
      chk("post-reset red_valid", red_valid, 1'b0);
    end

    // Random commands
    for (int n = 0; n < 25; n++) begin
      logic [31:0] vs2;
      vs2 = (n % 5 == 0) ? 32'hFFFF_FFFE : $urandom;
      do_cmd(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), 11'($urandom_range(0, 40)),
             vs2, {$urandom, $urandom}, $urandom, (n % 4 == 1), (n % 3 == 2),
             int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
